// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
package piso_pkg;

  // Serializer control states.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Parity modes selected by the PARITY parameter.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Parity bit for a word whose XOR-reduction is ones_odd.
  function automatic logic parity_bit(input int unsigned mode, input logic ones_odd);
    return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit index counter with synchronous clear and terminal-count flag.
module piso_bit_counter #(
  parameter int unsigned CntWidth = 3,
  parameter int unsigned LastIdx  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  output logic [CntWidth-1:0] count,
  output logic                tc
);

  logic [CntWidth-1:0] count_q;

  // Clear on load (new frame or frame end), otherwise count advanced bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CntWidth'(LastIdx));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-entry holding buffer, optional
// parity bit and gapless back-to-back framing.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned PARITY     = 0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned FrameLen = (PARITY != PAR_NONE) ? WIDTH + 1 : WIDTH;
  localparam int unsigned CntW     = $clog2(WIDTH + 2);

  state_e            state_q, state_d;
  logic              buf_full_q, buf_full_d;
  logic [WIDTH-1:0]  buf_q, buf_d;
  logic [WIDTH:0]    sr_q, sr_d;
  logic [WIDTH:0]    frame_word;
  logic [CntW-1:0]   cnt;
  logic              tc;
  logic              xfer, frame_end, load_word, advance;

  assign in_ready  = ~buf_full_q;
  assign xfer      = in_valid & in_ready;
  assign frame_end = (state_q == StShift) & shift_en & tc;
  assign load_word = buf_full_q & ((state_q == StIdle) | frame_end);
  assign advance   = (state_q == StShift) & shift_en & ~tc;
  assign busy      = (state_q == StShift) | buf_full_q;

  // Frame in transmit order: bit 0 leaves first, parity (if any) sits on top.
  always_comb begin
    frame_word = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      frame_word[i] = (MSB_FIRST != 0) ? buf_q[WIDTH-1-i] : buf_q[i];
    end
    if (PARITY != PAR_NONE) begin
      frame_word[WIDTH] = parity_bit(PARITY, ^buf_q);
    end
  end

  // Holding buffer: emptied by a load; a concurrent transfer refills it.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (load_word) begin
      buf_full_d = 1'b0;
    end
    if (xfer) begin
      buf_full_d = 1'b1;
      buf_d      = in_data;
    end
  end

  // Shift register: load a frame, shift right on each advanced bit.
  always_comb begin
    sr_d = sr_q;
    if (load_word) begin
      sr_d = frame_word;
    end else if (advance) begin
      sr_d = {1'b0, sr_q[WIDTH:1]};
    end else if (frame_end) begin
      sr_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      sr_q       <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      sr_q       <= sr_d;
    end
  end

  piso_bit_counter #(
    .CntWidth (CntW),
    .LastIdx  (FrameLen - 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .load  (load_word | frame_end),
    .en    (advance),
    .count (cnt),
    .tc    (tc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start on a buffered word, stop at a frame end with nothing queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (buf_full_q) state_d = StShift;
      StShift: if (frame_end && !buf_full_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: serial line is driven from the shift register only while shifting.
  always_comb begin
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    ser_out   = IDLE_LEVEL;
    if (state_q == StShift) begin
      ser_valid = 1'b1;
      ser_out   = sr_q[0];
      ser_first = (cnt == '0);
      ser_last  = tc;
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 sends LSB first, 1 sends MSB first.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd; when not 0, one parity bit follows the data bits.
REQ-004 SHALL have parameter IDLE_LEVEL, default 0, the ser_out level while no word is active.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  producer offers in_data.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  WIDTH  parallel word.
REQ-010 shift_en  input  1  bit-rate strobe; the output advances one bit on edges where it is 1.
REQ-011 ser_out  output  1  serial data bit.
REQ-012 ser_valid  output  1  ser_out carries a frame bit.
REQ-013 ser_first  output  1  ser_out is the first data bit of a word.
REQ-014 ser_last  output  1  ser_out is the final bit of the frame (parity bit if enabled).
REQ-015 busy  output  1  shifter active or holding buffer full.

Function
REQ-016 SHALL contain a one-entry holding buffer and a shift register with bit counter; FSM states IDLE and SHIFT.
REQ-017 in_ready SHALL equal NOT(holding buffer full); a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-018 An accepted word SHALL enter the holding buffer on the transfer edge.
REQ-019 In IDLE with the buffer full, the next edge SHALL load the shift register, clear the buffer and enter SHIFT, regardless of shift_en; first-bit latency is 2 edges from the transfer edge.
REQ-020 On load: ser_valid=1, ser_first=1, ser_out = in_data[0] (MSB_FIRST=0) or in_data[WIDTH-1] (MSB_FIRST=1).
REQ-021 In SHIFT, each edge with shift_en=1 SHALL advance one bit; with shift_en=0 all outputs hold.
REQ-022 Frame length SHALL be WIDTH bits, or WIDTH+1 bits when PARITY is not 0.
REQ-023 Parity SHALL be computed over the loaded word: even makes the total count of ones even; odd makes it odd.
REQ-024 ser_first SHALL be 1 only on bit 0; ser_last SHALL be 1 only on the final frame bit.
REQ-025 On a shift_en edge at the final bit: if the buffer is full, the next word SHALL load gaplessly (stay in SHIFT, ser_first=1); otherwise the block SHALL go to IDLE with ser_valid=0 and ser_out=IDLE_LEVEL.
REQ-026 A transfer and a gapless load on the same edge SHALL both occur: the buffer empties and refills, and in_ready stays 0.
REQ-027 busy SHALL be 1 in SHIFT or when the buffer is full; otherwise 0.

Reset
REQ-028 rst SHALL immediately clear the FSM to IDLE, empty the buffer, and zero the shift register and counter.
REQ-029 During reset: ser_out=IDLE_LEVEL; ser_valid, ser_first, ser_last and busy are 0; in_ready=1; transfers are ignored.
REQ-030 Reset mid-frame SHALL discard the partial word and the buffered word; the first transfer after release starts a fresh frame.

Structure
REQ-031 Package piso_pkg SHALL hold the FSM state enum and the parity-mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
REQ-032 Bit counter SHALL be a sub-module piso_bit_counter (width $clog2(WIDTH+2), with load, enable, terminal-count flag).

Verification
REQ-033 WIDTH=5, LSB-first, shift_en=1, 10110 -> ser_out 0,1,1,0,1 on 5 edges; ser_first on bit 1, ser_last on bit 5; then IDLE.
REQ-034 WIDTH=5, MSB_FIRST=1, 10110 -> ser_out 1,0,1,1,0.
REQ-035 Back-to-back 10110 then 01011 -> 10 consecutive valid bits with no gap; in_ready=0 while the buffer is full.
REQ-036 shift_en pulsed every 3rd cycle -> each bit held 3 cycles; ser_valid stays 1 throughout.
REQ-037 PARITY=1, 10110 -> 6 bits 0,1,1,0,1,1 with ser_last on the parity bit; PARITY=2 -> final bit 0.
REQ-038 rst asserted after 2 bits of 10110 -> outputs at reset values at once; after release, 00111 serializes from bit 0 with ser_first=1.
